pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central stall/flush controller for the 5-stage pipeline. It drives the enable and clear inputs of the PC register and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves three events: multi-cycle data-memory access, taken branch/jump, and load-use hazard. Its outputs are settled before the falling edge on which the pipeline registers capture.

## Interface
- `MEM_LAT`, default 2: total cycles a load/store occupies the MEM stage; must be ≥1; 1 means no wait.
- `CNT_W`, default 4: width of the wait counter; requires `MEM_LAT-1 < 2**CNT_W`.
- `STAT_W`, default 16: width of the stall statistics counter.

Ports (clock and reset first):
- `i_clk` in 1: single clock; controller state updates on the rising edge.
- `i_rst_n` in 1: reset, asynchronous and active-low.
- `i_id_rs1` in 5: rs1 index of the instruction in ID.
- `i_id_rs2` in 5: rs2 index of the instruction in ID.
- `i_ex_rd` in 5: rd index of the instruction in EX.
- `i_ex_mem_read` in 1: instruction in EX is a load.
- `i_ex_branch_taken` in 1: EX resolved a taken branch or jump.
- `i_mem_access` in 1: instruction in MEM is a load or store.
- `o_pc_en` out 1: PC register enable.
- `o_ifid_en` out 1 / `o_ifid_clr` out 1: IF/ID register enable and clear.
- `o_idex_en` out 1 / `o_idex_clr` out 1: ID/EX register enable and clear.
- `o_exmem_en` out 1 / `o_exmem_clr` out 1: EX/MEM register enable and clear.
- `o_memwb_en` out 1 / `o_memwb_clr` out 1: MEM/WB register enable and clear.
- `o_busy` out 1: a memory freeze is in progress.
- `o_stall_cycles` out STAT_W: saturating count of frozen or bubbled cycles.

## Operation
- FSM states:
  - RUN: normal flow.
  - MEM_WAIT: a multi-cycle memory access is in progress.
- Internal counter `cnt[CNT_W-1:0]`.

RUN state:
- Default outputs: all `*_en`=1, all `*_clr`=0.
- Memory freeze (highest priority):
  - Trigger: `i_mem_access`=1 and `MEM_LAT`>1.
  - Outputs: `o_pc_en`, `o_ifid_en`, `o_idex_en`, `o_exmem_en` = 0; `o_memwb_clr`=1, so no duplicate writeback.
  - Next: `cnt`←`MEM_LAT-1`; state←MEM_WAIT.
- Branch flush (second priority):
  - Trigger: `i_ex_branch_taken`=1.
  - Outputs: `o_ifid_clr`=1, `o_idex_clr`=1, `o_pc_en`=1 so the target is loaded.
  - A simultaneous load-use condition is ignored.
- Load-use bubble (third priority):
  - Trigger: `i_ex_mem_read`=1, `i_ex_rd`≠0, and `i_ex_rd` equals `i_id_rs1` or `i_id_rs2`.
  - Outputs: `o_pc_en`=0, `o_ifid_en`=0, `o_idex_clr`=1.

MEM_WAIT state:
- While `cnt`>1: same freeze outputs as the RUN-state memory freeze; `cnt` decrements each cycle. Branch and load-use inputs are ignored; they persist because EX is frozen.
- When `cnt`==1 (release cycle):
  - Outputs are the normal RUN evaluation of branch and load-use; `i_mem_access` is ignored in this cycle.
  - Next: state←RUN, `cnt`←0.
- Result: the access instruction occupies MEM for exactly `MEM_LAT` cycles; `MEM_LAT-1` of them are frozen.

Other behaviour:
- `o_busy` = 1 in any freeze cycle, in either state.
- `o_stall_cycles` increments once per cycle in which any freeze, flush or bubble is asserted. It saturates at all-ones and never wraps.
- Clear has priority over enable at every register. The controller never asserts clear and enable-low on the same register in one cycle, except MEM/WB during a freeze, where only the clear is asserted.

## Timing
- Reset values: state=RUN, `cnt`=0, `o_stall_cycles`=0. Outputs then follow RUN decoding: all `*_en`=1, `*_clr`=0, `o_busy`=0, unless inputs request otherwise.
- Reset asserted mid-MEM_WAIT: state and counter return to reset values immediately; no release cycle occurs.
- Outputs are combinational from state, `cnt` and inputs. Zero-cycle latency from input to output.
- State, `cnt` and the statistics counter update on the rising edge. Outputs must be stable by the falling edge.
- Back-to-back accesses: a new access arriving in MEM on the cycle after release triggers a fresh freeze. There is no dead cycle.

## Structure
- Package `pipeline_ctrl_pkg` holds:
  - state encoding (RUN=0, MEM_WAIT=1);
  - register-index width constant (5);
  - x0 index constant.
- Single module with no sub-module. The hazard compare, the FSM with counter, and the statistics counter are all inline.

## Test plan
- Load-use: `i_ex_mem_read`=1, `i_ex_rd`=5, `i_id_rs2`=5 → one cycle with `o_pc_en`=0, `o_ifid_en`=0, `o_idex_clr`=1; `o_stall_cycles` goes 0→1. Repeat with `i_ex_rd`=0 → no stall.
- Branch with simultaneous load-use match → `o_ifid_clr`=1, `o_idex_clr`=1, `o_pc_en`=1, `o_ifid_en`=1.
- `MEM_LAT`=4, `i_mem_access` held high → exactly 3 freeze cycles with `o_busy`=1 and `o_memwb_clr`=1, then a release cycle with all enables=1; `o_stall_cycles`=3.
- `MEM_LAT`=3, `i_ex_branch_taken`=1 throughout the freeze → no flush during the 2 frozen cycles; flush asserted in the release cycle.
- Assert `i_rst_n`=0 in the second frozen cycle with `MEM_LAT`=4 → state=RUN, `o_stall_cycles`=0 and `o_busy`=0 immediately (asynchronous).
- `STAT_W`=4, drive 20 continuous stall cycles → `o_stall_cycles` holds at 15.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
// Holds the FSM encoding, the register-index width and the x0 index.
package pipeline_ctrl_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] X0_IDX = '0;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_e;

  // A load in EX feeding either source of the instruction in ID; x0 never creates a dependency.
  function automatic logic load_use_hit(input logic             mem_read,
                                        input logic [REG_W-1:0] rd,
                                        input logic [REG_W-1:0] rs1,
                                        input logic [REG_W-1:0] rs2);
    return mem_read && (rd != X0_IDX) && ((rd == rs1) || (rd == rs2));
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of hazard inputs and stage enable/clear outputs around the controller.
// The ctrl modport is the controller's view; pipe is the datapath's view.
interface pipeline_hazard_ctrl_if #(
  parameter int STAT_W = 16
);
  import pipeline_ctrl_pkg::*;

  logic [REG_W-1:0]  id_rs1;
  logic [REG_W-1:0]  id_rs2;
  logic [REG_W-1:0]  ex_rd;
  logic              ex_mem_read;
  logic              ex_branch_taken;
  logic              mem_access;
  logic              pc_en;
  logic              ifid_en;
  logic              ifid_clr;
  logic              idex_en;
  logic              idex_clr;
  logic              exmem_en;
  logic              exmem_clr;
  logic              memwb_en;
  logic              memwb_clr;
  logic              busy;
  logic [STAT_W-1:0] stall_cycles;

  modport ctrl (
    input  id_rs1, id_rs2, ex_rd, ex_mem_read, ex_branch_taken, mem_access,
    output pc_en, ifid_en, ifid_clr, idex_en, idex_clr, exmem_en, exmem_clr,
           memwb_en, memwb_clr, busy, stall_cycles
  );

  modport pipe (
    output id_rs1, id_rs2, ex_rd, ex_mem_read, ex_branch_taken, mem_access,
    input  pc_en, ifid_en, ifid_clr, idex_en, idex_clr, exmem_en, exmem_clr,
           memwb_en, memwb_clr, busy, stall_cycles
  );

endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: memory freeze,
// branch flush and load-use bubble, in that priority, plus a stall statistic.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 4,
  parameter int STAT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [REG_W-1:0]  i_id_rs1,
  input  logic [REG_W-1:0]  i_id_rs2,
  input  logic [REG_W-1:0]  i_ex_rd,
  input  logic              i_ex_mem_read,
  input  logic              i_ex_branch_taken,
  input  logic              i_mem_access,
  output logic              o_pc_en,
  output logic              o_ifid_en,
  output logic              o_ifid_clr,
  output logic              o_idex_en,
  output logic              o_idex_clr,
  output logic              o_exmem_en,
  output logic              o_exmem_clr,
  output logic              o_memwb_en,
  output logic              o_memwb_clr,
  output logic              o_busy,
  output logic [STAT_W-1:0] o_stall_cycles
);

  localparam logic [CNT_W-1:0] CNT_LOAD    = CNT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic             MULTI_CYCLE = (MEM_LAT > 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STAT_W-1:0] stat_q, stat_d;

  logic freeze;
  logic flush;
  logic bubble;

  // In MEM_WAIT the release cycle (cnt==1) falls through to normal RUN decoding,
  // which deliberately ignores i_mem_access for that one cycle.
  assign freeze = (state_q == ST_MEM_WAIT) ? (cnt_q > CNT_ONE)
                                           : (MULTI_CYCLE && i_mem_access);
  assign flush  = !freeze && i_ex_branch_taken;
  assign bubble = !freeze && !i_ex_branch_taken &&
                  load_use_hit(i_ex_mem_read, i_ex_rd, i_id_rs1, i_id_rs2);

  // Enables stay high on any register being cleared, so clear never meets enable-low
  // except MEM/WB during a freeze.
  assign o_pc_en        = !(freeze || bubble);
  assign o_ifid_en      = !(freeze || bubble);
  assign o_ifid_clr     = flush;
  assign o_idex_en      = !freeze;
  assign o_idex_clr     = flush || bubble;
  assign o_exmem_en     = !freeze;
  assign o_exmem_clr    = 1'b0;
  assign o_memwb_en     = 1'b1;
  assign o_memwb_clr    = freeze;
  assign o_busy         = freeze;
  assign o_stall_cycles = stat_q;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    stat_d  = stat_q;

    case (state_q)
      ST_RUN: begin
        if (freeze) begin
          state_d = ST_MEM_WAIT;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_MEM_WAIT: begin
        if (freeze) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    endcase

    if ((freeze || flush || bubble) && (stat_q != '1)) begin
      stat_d = stat_q + STAT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      stat_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so all state updates see pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stat_q  <= stat_d;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl across three parameter sets
// (MEM_LAT=2, MEM_LAT=4, MEM_LAT=3 with a 4-bit statistic) sharing one input stream.
module tb_pipeline_hazard_ctrl;
  import pipeline_ctrl_pkg::*;

  // Packed view: {pc_en, ifid_en, ifid_clr, idex_en, idex_clr, exmem_en, exmem_clr, memwb_en, memwb_clr, busy}
  localparam logic [9:0] V_NORMAL = 10'b11_01_01_01_0_0 ^ 10'b00_00_00_00_0_0;
  localparam logic [9:0] V_BUBBLE = 10'b0001110100;
  localparam logic [9:0] V_FLUSH  = 10'b1111110100;
  localparam logic [9:0] V_FREEZE = 10'b0000000111;

  logic i_clk;
  logic i_rst_n;
  logic [REG_W-1:0] id_rs1, id_rs2, ex_rd;
  logic ex_mem_read, ex_branch_taken, mem_access;

  int checks = 0;
  int errors = 0;

  pipeline_hazard_ctrl_if #(.STAT_W(16)) b2 ();
  pipeline_hazard_ctrl_if #(.STAT_W(16)) b4 ();
  pipeline_hazard_ctrl_if #(.STAT_W(4))  b3 ();

  assign b2.id_rs1 = id_rs1;  assign b4.id_rs1 = id_rs1;  assign b3.id_rs1 = id_rs1;
  assign b2.id_rs2 = id_rs2;  assign b4.id_rs2 = id_rs2;  assign b3.id_rs2 = id_rs2;
  assign b2.ex_rd  = ex_rd;   assign b4.ex_rd  = ex_rd;   assign b3.ex_rd  = ex_rd;
  assign b2.ex_mem_read = ex_mem_read;  assign b4.ex_mem_read = ex_mem_read;
  assign b3.ex_mem_read = ex_mem_read;
  assign b2.ex_branch_taken = ex_branch_taken;  assign b4.ex_branch_taken = ex_branch_taken;
  assign b3.ex_branch_taken = ex_branch_taken;
  assign b2.mem_access = mem_access;  assign b4.mem_access = mem_access;
  assign b3.mem_access = mem_access;

  wire [9:0] ctl2 = {b2.pc_en, b2.ifid_en, b2.ifid_clr, b2.idex_en, b2.idex_clr,
                     b2.exmem_en, b2.exmem_clr, b2.memwb_en, b2.memwb_clr, b2.busy};
  wire [9:0] ctl4 = {b4.pc_en, b4.ifid_en, b4.ifid_clr, b4.idex_en, b4.idex_clr,
                     b4.exmem_en, b4.exmem_clr, b4.memwb_en, b4.memwb_clr, b4.busy};
  wire [9:0] ctl3 = {b3.pc_en, b3.ifid_en, b3.ifid_clr, b3.idex_en, b3.idex_clr,
                     b3.exmem_en, b3.exmem_clr, b3.memwb_en, b3.memwb_clr, b3.busy};

  pipeline_hazard_ctrl #(.MEM_LAT(2), .CNT_W(4), .STAT_W(16)) dut2 (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_id_rs1(b2.id_rs1), .i_id_rs2(b2.id_rs2), .i_ex_rd(b2.ex_rd),
    .i_ex_mem_read(b2.ex_mem_read), .i_ex_branch_taken(b2.ex_branch_taken),
    .i_mem_access(b2.mem_access),
    .o_pc_en(b2.pc_en), .o_ifid_en(b2.ifid_en), .o_ifid_clr(b2.ifid_clr),
    .o_idex_en(b2.idex_en), .o_idex_clr(b2.idex_clr),
    .o_exmem_en(b2.exmem_en), .o_exmem_clr(b2.exmem_clr),
    .o_memwb_en(b2.memwb_en), .o_memwb_clr(b2.memwb_clr),
    .o_busy(b2.busy), .o_stall_cycles(b2.stall_cycles)
  );

  pipeline_hazard_ctrl #(.MEM_LAT(4), .CNT_W(4), .STAT_W(16)) dut4 (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_id_rs1(b4.id_rs1), .i_id_rs2(b4.id_rs2), .i_ex_rd(b4.ex_rd),
    .i_ex_mem_read(b4.ex_mem_read), .i_ex_branch_taken(b4.ex_branch_taken),
    .i_mem_access(b4.mem_access),
    .o_pc_en(b4.pc_en), .o_ifid_en(b4.ifid_en), .o_ifid_clr(b4.ifid_clr),
    .o_idex_en(b4.idex_en), .o_idex_clr(b4.idex_clr),
    .o_exmem_en(b4.exmem_en), .o_exmem_clr(b4.exmem_clr),
    .o_memwb_en(b4.memwb_en), .o_memwb_clr(b4.memwb_clr),
    .o_busy(b4.busy), .o_stall_cycles(b4.stall_cycles)
  );

  pipeline_hazard_ctrl #(.MEM_LAT(3), .CNT_W(4), .STAT_W(4)) dut3 (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_id_rs1(b3.id_rs1), .i_id_rs2(b3.id_rs2), .i_ex_rd(b3.ex_rd),
    .i_ex_mem_read(b3.ex_mem_read), .i_ex_branch_taken(b3.ex_branch_taken),
    .i_mem_access(b3.mem_access),
    .o_pc_en(b3.pc_en), .o_ifid_en(b3.ifid_en), .o_ifid_clr(b3.ifid_clr),
    .o_idex_en(b3.idex_en), .o_idex_clr(b3.idex_clr),
    .o_exmem_en(b3.exmem_en), .o_exmem_clr(b3.exmem_clr),
    .o_memwb_en(b3.memwb_en), .o_memwb_clr(b3.memwb_clr),
    .o_busy(b3.busy), .o_stall_cycles(b3.stall_cycles)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic set_idle();
    id_rs1 = 5'd1; id_rs2 = 5'd2; ex_rd = 5'd0;
    ex_mem_read = 1'b0; ex_branch_taken = 1'b0; mem_access = 1'b0;
  endtask

  // Leaves time at 1 unit after a rising edge with reset released.
  task automatic do_reset();
    set_idle();
    i_rst_n = 1'b0;
    repeat (2) @(posedge i_clk);
    #1 i_rst_n = 1'b1;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge i_clk);
    checks++;
    if (ctl2 !== V_NORMAL) begin
      errors++; $display("FAIL reset_ctl got %b want %b", ctl2, V_NORMAL);
    end
    checks++;
    if (b2.stall_cycles !== 16'd0) begin
      errors++; $display("FAIL reset_stat got %0d want 0", b2.stall_cycles);
    end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd1; id_rs2 = 5'd5;
    @(negedge i_clk);
    checks++;
    if (ctl2 !== V_BUBBLE) begin
      errors++; $display("FAIL lu_rs2_ctl got %b want %b", ctl2, V_BUBBLE);
    end
    tick();
    set_idle();
    @(negedge i_clk);
    checks++;
    if (b2.stall_cycles !== 16'd1) begin
      errors++; $display("FAIL lu_stat got %0d want 1", b2.stall_cycles);
    end
    checks++;
    if (ctl2 !== V_NORMAL) begin
      errors++; $display("FAIL lu_after_ctl got %b want %b", ctl2, V_NORMAL);
    end
    tick();
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs2 = 5'd0;
    @(negedge i_clk);
    checks++;
    if (ctl2 !== V_NORMAL) begin
      errors++; $display("FAIL lu_x0_ctl got %b want %b", ctl2, V_NORMAL);
    end
    tick();
    ex_rd = 5'd7; id_rs1 = 5'd7; id_rs2 = 5'd3;
    @(negedge i_clk);
    checks++;
    if (ctl2 !== V_BUBBLE) begin
      errors++; $display("FAIL lu_rs1_ctl got %b want %b", ctl2, V_BUBBLE);
    end
    tick();
    set_idle();
    @(negedge i_clk);
    checks++;
    if (b2.stall_cycles !== 16'd2) begin
      errors++; $display("FAIL lu_stat2 got %0d want 2", b2.stall_cycles);
    end
    tick();
  endtask

  task automatic test_branch();
    do_reset();
    ex_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9;
    @(negedge i_clk);
    checks++;
    if (ctl2 !== V_FLUSH) begin
      errors++; $display("FAIL br_lu_ctl got %b want %b", ctl2, V_FLUSH);
    end
    tick();
    set_idle();
    @(negedge i_clk);
    checks++;
    if (b2.stall_cycles !== 16'd1) begin
      errors++; $display("FAIL br_stat got %0d want 1", b2.stall_cycles);
    end
    tick();
  endtask

  task automatic test_mem_freeze();
    do_reset();
    mem_access = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      checks++;
      if (ctl4 !== V_FREEZE) begin
        errors++; $display("FAIL frz4_c%0d_ctl got %b want %b", i, ctl4, V_FREEZE);
      end
      if (i == 1) begin
        checks++;
        if (ctl2 !== V_NORMAL) begin
          errors++; $display("FAIL frz2_release_ctl got %b want %b", ctl2, V_NORMAL);
        end
      end
      tick();
    end
    @(negedge i_clk);
    checks++;
    if (ctl4 !== V_NORMAL) begin
      errors++; $display("FAIL frz4_release_ctl got %b want %b", ctl4, V_NORMAL);
    end
    checks++;
    if (b4.stall_cycles !== 16'd3) begin
      errors++; $display("FAIL frz4_stat got %0d want 3", b4.stall_cycles);
    end
    tick();
    @(negedge i_clk);
    checks++;
    if (ctl4 !== V_FREEZE) begin
      errors++; $display("FAIL back_to_back_ctl got %b want %b", ctl4, V_FREEZE);
    end
    checks++;
    if (b4.stall_cycles !== 16'd3) begin
      errors++; $display("FAIL back_to_back_stat got %0d want 3", b4.stall_cycles);
    end
    tick();
    set_idle();
  endtask

  task automatic test_branch_in_freeze();
    do_reset();
    mem_access = 1'b1; ex_branch_taken = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge i_clk);
      checks++;
      if (ctl3 !== V_FREEZE) begin
        errors++; $display("FAIL brfrz_c%0d_ctl got %b want %b", i, ctl3, V_FREEZE);
      end
      tick();
      mem_access = 1'b0;
    end
    @(negedge i_clk);
    checks++;
    if (ctl3 !== V_FLUSH) begin
      errors++; $display("FAIL brfrz_release_ctl got %b want %b", ctl3, V_FLUSH);
    end
    tick();
    set_idle();
    @(negedge i_clk);
    checks++;
    if (b3.stall_cycles !== 4'd3) begin
      errors++; $display("FAIL brfrz_stat got %0d want 3", b3.stall_cycles);
    end
    tick();
  endtask

  task automatic test_reset_mid_freeze();
    do_reset();
    mem_access = 1'b1;
    tick();
    mem_access = 1'b0;
    @(negedge i_clk);
    checks++;
    if ((ctl4 !== V_FREEZE) || (b4.stall_cycles !== 16'd1)) begin
      errors++; $display("FAIL midrst_pre got %b/%0d want %b/1", ctl4, b4.stall_cycles, V_FREEZE);
    end
    #2 i_rst_n = 1'b0;
    #1;
    checks++;
    if ((ctl4 !== V_NORMAL) || (b4.stall_cycles !== 16'd0) || (b4.busy !== 1'b0)) begin
      errors++; $display("FAIL midrst_async got %b/%0d want %b/0", ctl4, b4.stall_cycles, V_NORMAL);
    end
    tick();
    i_rst_n = 1'b1;
    tick();
    @(negedge i_clk);
    checks++;
    if ((ctl4 !== V_NORMAL) || (b4.stall_cycles !== 16'd0)) begin
      errors++; $display("FAIL midrst_after got %b/%0d want %b/0", ctl4, b4.stall_cycles, V_NORMAL);
    end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3;
    repeat (15) tick();
    @(negedge i_clk);
    checks++;
    if (b3.stall_cycles !== 4'd15) begin
      errors++; $display("FAIL sat_15 got %0d want 15", b3.stall_cycles);
    end
    tick();
    repeat (4) tick();
    @(negedge i_clk);
    checks++;
    if (b3.stall_cycles !== 4'd15) begin
      errors++; $display("FAIL sat_hold got %0d want 15", b3.stall_cycles);
    end
    checks++;
    if (b2.stall_cycles !== 16'd20) begin
      errors++; $display("FAIL wide_20 got %0d want 20", b2.stall_cycles);
    end
    tick();
    set_idle();
  endtask

  initial begin
    set_idle();
    i_rst_n = 1'b0;
    test_reset();
    test_load_use();
    test_branch();
    test_mem_freeze();
    test_branch_in_freeze();
    test_reset_mid_freeze();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
